// File: rtl/l2_block_responder_if.sv
// Bus bundle between the L2 bus controller (master) and the block responder (slave).
//   l2REN / l2WEN : block read / write request, held for the whole transaction
//   l2addr        : byte address of the block
//   l2store       : block data to write
//   l2load        : block data returned by the last completed read
//   l2state       : responder status, FREE=0 BUSY=1 ACCESS=2 ERROR=3
interface l2_block_responder_if #(
    parameter int unsigned BLOCK_SIZE_WORDS = 2,
    parameter int unsigned WORD_W           = 32
);
    localparam int unsigned BLOCK_W = BLOCK_SIZE_WORDS * WORD_W;

    logic               l2REN;
    logic               l2WEN;
    logic [WORD_W-1:0]  l2addr;
    logic [BLOCK_W-1:0] l2store;
    logic [BLOCK_W-1:0] l2load;
    logic [1:0]         l2state;

    modport master (
        output l2REN, l2WEN, l2addr, l2store,
        input  l2load, l2state
    );

    modport slave (
        input  l2REN, l2WEN, l2addr, l2store,
        output l2load, l2state
    );
endinterface

// File: rtl/l2_block_responder.sv
// Block-granular L2 responder: a DEPTH_BLOCKS-entry block store that answers one
// read or write at a time after a programmable number of BUSY cycles.
// Ports:
//   CLK   : clock, all state changes on the rising edge
//   nRST  : asynchronous active-low reset (clears state, l2load and all blocks)
//   bus   : l2_block_responder_if.slave (l2REN, l2WEN, l2addr, l2store in;
//           l2load, l2state out)
// Build option:
//   L2_RAND_LATENCY_EN : when defined, each accepted request waits
//   (LFSR mod RAND_RANGE)+1 cycles from a free-running 16-bit Galois LFSR;
//   otherwise every request waits LATENCY cycles.
module l2_block_responder #(
    parameter int unsigned BLOCK_SIZE_WORDS = 2,
    parameter int unsigned WORD_W           = 32,
    parameter int unsigned DEPTH_BLOCKS     = 64,
    parameter int unsigned LATENCY          = 4,
    parameter int unsigned RAND_RANGE       = 10
) (
    input  logic                 CLK,
    input  logic                 nRST,
    l2_block_responder_if.slave  bus
);
    localparam int unsigned BLOCK_W = BLOCK_SIZE_WORDS * WORD_W;
    localparam int unsigned OFF_W   = $clog2(BLOCK_W / 8);
    localparam int unsigned IDX_W   = $clog2(DEPTH_BLOCKS);
    localparam int unsigned TOP_LSB = OFF_W + IDX_W;
    localparam int unsigned CNT_W   = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        FAULT  = 2'd3
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               op_wr;
    logic [IDX_W-1:0]   idx_q;
    logic [BLOCK_W-1:0] store_q;
    logic [BLOCK_W-1:0] load_q;
    logic [BLOCK_W-1:0] mem [DEPTH_BLOCKS];

    logic [IDX_W-1:0]   req_idx_c;
    logic               req_oor_c;
    logic               req_held_c;
    logic [CNT_W-1:0]   req_lat_c;

    // Request decode: block index field and any address bit above it.
    always_comb begin
        req_idx_c  = bus.l2addr[OFF_W +: IDX_W];
        req_oor_c  = (bus.l2addr >> TOP_LSB) != '0;
        req_held_c = op_wr ? bus.l2WEN : bus.l2REN;
    end

`ifdef L2_RAND_LATENCY_EN
    logic [15:0] lfsr;

    // Free-running Galois LFSR, taps 16,14,13,11.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
        end
    end

    assign req_lat_c = CNT_W'((lfsr % 16'(RAND_RANGE)) + 16'd1);
`else
    assign req_lat_c = CNT_W'(LATENCY);
`endif

    // Request FSM, latency counter, read capture and block store.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state   <= IDLE;
            cnt     <= '0;
            op_wr   <= 1'b0;
            idx_q   <= '0;
            store_q <= '0;
            load_q  <= '0;
            for (int i = 0; i < DEPTH_BLOCKS; i++) begin
                mem[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (bus.l2REN && bus.l2WEN) begin
                        state <= FAULT;
                    end else if (bus.l2REN || bus.l2WEN) begin
                        if (req_oor_c) begin
                            state <= FAULT;
                        end else begin
                            op_wr   <= bus.l2WEN;
                            idx_q   <= req_idx_c;
                            store_q <= bus.l2store;
                            cnt     <= req_lat_c;
                            if (req_lat_c == '0) begin
                                state <= ACCESS;
                                if (!bus.l2WEN) begin
                                    load_q <= mem[req_idx_c];
                                end
                            end else begin
                                state <= WAIT;
                            end
                        end
                    end
                end
                WAIT: begin
                    // A dropped request abandons the access with no side effects.
                    if (!req_held_c) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_W'(1)) begin
                        state <= ACCESS;
                        cnt   <= '0;
                        if (!op_wr) begin
                            load_q <= mem[idx_q];
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ACCESS: begin
                    // Write lands on the edge that leaves ACCESS; inputs ignored here.
                    state <= IDLE;
                    if (op_wr) begin
                        mem[idx_q] <= store_q;
                    end
                end
                FAULT: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Status decode from the state register only.
    always_comb begin
        bus.l2state = 2'd0;
        case (state)
            IDLE:    bus.l2state = 2'd0;
            WAIT:    bus.l2state = 2'd1;
            ACCESS:  bus.l2state = 2'd2;
            FAULT:   bus.l2state = 2'd3;
            default: bus.l2state = 2'd0;
        endcase
    end

    assign bus.l2load = load_q;

endmodule

// File: tb/tb_l2_block_responder.sv
// Self-checking bench for l2_block_responder: directed scenarios plus randomized
// transactions, compared every cycle against a transaction-level model.
// Works in the default build and with L2_RAND_LATENCY_EN defined.
module tb_l2_block_responder;
    localparam int unsigned BSW   = 2;
    localparam int unsigned WW    = 32;
    localparam int unsigned DEPTH = 64;
    localparam int unsigned LAT   = 4;
    localparam int unsigned RR    = 10;
    localparam int unsigned BW    = BSW * WW;
    localparam int unsigned OFF_W = $clog2(BW / 8);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned TOP   = OFF_W + IDX_W;
    localparam int          NRAND = 300;

    localparam logic [1:0] ST_FREE   = 2'd0;
    localparam logic [1:0] ST_BUSY   = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_ERROR  = 2'd3;

    logic CLK = 1'b0;
    logic nRST;
    always #5 CLK = ~CLK;

    l2_block_responder_if #(.BLOCK_SIZE_WORDS(BSW), .WORD_W(WW)) bus ();

    l2_block_responder #(
        .BLOCK_SIZE_WORDS(BSW),
        .WORD_W          (WW),
        .DEPTH_BLOCKS    (DEPTH),
        .LATENCY         (LAT),
        .RAND_RANGE      (RR)
    ) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    // Model state
    logic [BW-1:0] mem_m [DEPTH];
    logic [1:0]    exp_state;
    logic [BW-1:0] exp_load;
    bit            chk_en;
    int            checks;
    int            failures;

    // BUSY run-length watcher
    int run_len;
    int last_run;
    int runs[$];

`ifdef L2_RAND_LATENCY_EN
    logic [15:0] tb_lfsr;
    always @(posedge CLK or negedge nRST) begin
        if (!nRST) tb_lfsr <= 16'hACE1;
        else       tb_lfsr <= tb_lfsr[0] ? ((tb_lfsr >> 1) ^ 16'hB400) : (tb_lfsr >> 1);
    end
`endif

    // Per-cycle compare against the model
    always @(negedge CLK) begin
        if (chk_en) begin
            checks++;
            if (bus.l2state !== exp_state) begin
                failures++;
                $display("FAIL state t=%0t got=%0d exp=%0d", $time, bus.l2state, exp_state);
            end
            checks++;
            if (bus.l2load !== exp_load) begin
                failures++;
                $display("FAIL load t=%0t got=%h exp=%h", $time, bus.l2load, exp_load);
            end
        end
    end

    always @(negedge CLK) begin
        if (!nRST) begin
            run_len = 0;
        end else if (bus.l2state == ST_BUSY) begin
            run_len++;
        end else if (run_len > 0) begin
            last_run = run_len;
            runs.push_back(run_len);
            run_len = 0;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drop_req();
        bus.l2REN = 1'b0;
        bus.l2WEN = 1'b0;
    endtask

    task automatic check_lit(input string name, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
        exp_state = ST_FREE;
        exp_load  = '0;
    endtask

    function automatic logic [BW-1:0] rand_block();
        logic [BW-1:0] b;
        for (int w = 0; w < BSW; w++) b[w*WW +: WW] = WW'($urandom);
        return b;
    endfunction

    // One transaction, called in a FREE cycle right after an edge; returns in a FREE cycle.
    task automatic do_txn(input bit wr, input bit both, input logic [WW-1:0] addr,
                          input logic [BW-1:0] data, input bit abort, input bit hold);
        int idx;
        bit oor;
        int lat;
        int drop_at;
        idx = int'(addr[OFF_W +: IDX_W]);
        oor = (addr >> TOP) != 0;
`ifdef L2_RAND_LATENCY_EN
        lat = int'(tb_lfsr % 16'(RR)) + 1;
`else
        lat = LAT;
`endif
        drop_at = (abort && lat > 0) ? int'($urandom_range(1, lat)) : 0;
        bus.l2addr  = addr;
        bus.l2store = data;
        bus.l2WEN   = wr || both;
        bus.l2REN   = !wr || both;
        tick();
        if (both || oor) begin
            exp_state = ST_ERROR;
            drop_req();
            tick();
            exp_state = ST_FREE;
            return;
        end
        for (int c = 1; c <= lat; c++) begin
            exp_state = ST_BUSY;
            if (c == drop_at) begin
                drop_req();
                tick();
                exp_state = ST_FREE;
                return;
            end
            tick();
        end
        exp_state = ST_ACCESS;
        if (!wr) exp_load = mem_m[idx];
        if (!hold) drop_req();
        tick();
        if (wr) mem_m[idx] = data;
        exp_state = ST_FREE;
        drop_req();
    endtask

    initial begin
        logic [BW-1:0] blk;
        logic [WW-1:0] a;
        bit            wr;
        int            sel;
        int            idx;
        checks   = 0;
        failures = 0;
        chk_en   = 1'b0;
        run_len  = 0;
        last_run = 0;
        nRST     = 1'b0;
        drop_req();
        bus.l2addr  = '0;
        bus.l2store = '0;
        clear_model();
        repeat (2) @(posedge CLK);
        #1;
        check_lit("reset_state", BW'(bus.l2state), BW'(ST_FREE));
        check_lit("reset_load", bus.l2load, '0);
        nRST   = 1'b1;
        chk_en = 1'b1;
        tick();

        // Write then read back the same block
        do_txn(1'b1, 1'b0, 32'h10, 64'hDEADBEEF_12345678, 1'b0, 1'b0);
`ifndef L2_RAND_LATENCY_EN
        check_lit("busy_len_write", BW'(last_run), BW'(4));
`endif
        do_txn(1'b0, 1'b0, 32'h10, '0, 1'b0, 1'b0);
        check_lit("read_0x10", bus.l2load, 64'hDEADBEEF_12345678);

        // Both requests at once: one ERROR cycle, block untouched
        do_txn(1'b1, 1'b1, 32'h18, 64'h1111_2222_3333_4444, 1'b0, 1'b0);
        do_txn(1'b0, 1'b0, 32'h18, '0, 1'b0, 1'b0);
        check_lit("read_after_both", bus.l2load, '0);

        // Out-of-range read leaves l2load alone
        do_txn(1'b0, 1'b0, 32'h10, '0, 1'b0, 1'b0);
        do_txn(1'b0, 1'b0, 32'h1000, '0, 1'b0, 1'b0);
        check_lit("load_after_oor", bus.l2load, 64'hDEADBEEF_12345678);

        // Write abandoned after two BUSY cycles
        bus.l2addr  = 32'h8;
        bus.l2store = 64'hCAFE_F00D_0BAD_BEEF;
        bus.l2WEN   = 1'b1;
        tick();
        exp_state = ST_BUSY;
        tick();
        drop_req();
        tick();
        check_lit("abort_state", BW'(bus.l2state), BW'(ST_FREE));
        exp_state = ST_FREE;
        tick();
        do_txn(1'b0, 1'b0, 32'h8, '0, 1'b0, 1'b0);
        check_lit("read_after_abort", bus.l2load, '0);

        // Reset in the middle of a write
        do_txn(1'b0, 1'b0, 32'h10, '0, 1'b0, 1'b0);
        bus.l2addr  = 32'h10;
        bus.l2store = 64'h5555_6666_7777_8888;
        bus.l2WEN   = 1'b1;
        tick();
        exp_state = ST_BUSY;
        tick();
        nRST = 1'b0;
        drop_req();
        clear_model();
        #1;
        check_lit("midreset_state", BW'(bus.l2state), BW'(ST_FREE));
        check_lit("midreset_load", bus.l2load, '0);
        tick();
        nRST = 1'b1;
        tick();
        do_txn(1'b0, 1'b0, 32'h10, '0, 1'b0, 1'b0);
        check_lit("read_after_reset", bus.l2load, '0);

        // Randomized traffic
        for (int n = 0; n < NRAND; n++) begin
            wr  = 1'($urandom_range(0, 1));
            sel = int'($urandom_range(0, 99));
            idx = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, DEPTH - 1));
            a   = (WW'(idx) << OFF_W) | WW'($urandom_range(0, (1 << OFF_W) - 1));
            if (sel < 5) a = a | (WW'(1) << $urandom_range(TOP, WW - 1));
            blk = rand_block();
            do_txn(wr, sel >= 5 && sel < 10, a, blk, sel >= 10 && sel < 25, sel >= 60);
            repeat ($urandom_range(0, 2)) tick();
        end

`ifdef L2_RAND_LATENCY_EN
        // Randomized latency: run lengths in range and not all equal
        begin
            int mn;
            int mx;
            runs.delete();
            for (int n = 0; n < 100; n++) do_txn(1'b0, 1'b0, 32'h0, '0, 1'b0, 1'b0);
            mn = 1000;
            mx = 0;
            foreach (runs[i]) begin
                if (runs[i] < mn) mn = runs[i];
                if (runs[i] > mx) mx = runs[i];
            end
            check_lit("rand_run_count", BW'(runs.size()), BW'(100));
            checks++;
            if (mn < 1 || mx > int'(RR)) begin
                failures++;
                $display("FAIL rand_busy_range min=%0d max=%0d exp within 1..%0d", mn, mx, RR);
            end
            checks++;
            if (mn == mx) begin
                failures++;
                $display("FAIL rand_busy_vary min=%0d max=%0d exp different", mn, mx);
            end
        end
`endif

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
